// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: drives a 32-bit request/ready data port,
// splitting 128-bit vector accesses into four word beats.
module mem_stage_lsu (
  input  logic         clock,
  input  logic         async_reset,
  input  logic         sync_reset,
  input  logic         memory_transaction_M,
  input  logic         mem_write_M,
  input  logic [2:0]   width_type_M,
  input  logic [127:0] ALU_result_bus_M,
  input  logic [127:0] write_data_bus_M,
  input  logic         mem_ready,
  input  logic [31:0]  mem_rdata,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  output logic [3:0]   mem_be,
  output logic         stall,
  output logic [127:0] load_data,
  output logic         load_valid
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } beat_t;

  localparam logic [2:0] W_B   = 3'b000;
  localparam logic [2:0] W_H   = 3'b001;
  localparam logic [2:0] W_BU  = 3'b100;
  localparam logic [2:0] W_HU  = 3'b101;
  localparam logic [2:0] W_VEC = 3'b111;

  function automatic beat_t mk_beat(
    input logic [2:0]   w,
    input logic [31:0]  a,
    input logic [127:0] d,
    input logic [1:0]   k
  );
    beat_t b;
    b.addr  = {a[31:2], 2'b00};
    b.wdata = d[31:0];
    b.be    = 4'hF;
    unique case (1'b1)
      (w == W_VEC): begin
        b.addr  = {a[31:4], 4'b0000} + {28'd0, k, 2'b00};
        b.wdata = d[{k, 5'd0} +: 32];
      end
      (w[1:0] == 2'b00): begin
        b.be    = 4'b0001 << a[1:0];
        b.wdata = {4{d[7:0]}};
      end
      (w[1:0] == 2'b01): begin
        b.be    = a[1] ? 4'b1100 : 4'b0011;
        b.wdata = {2{d[15:0]}};
      end
      default: ;
    endcase
    return b;
  endfunction

  function automatic logic [31:0] ld_ext(
    input logic [2:0]  w,
    input logic [31:0] a,
    input logic [31:0] r
  );
    logic [7:0]  by;
    logic [15:0] hw;
    logic [31:0] res;
    by  = r[{a[1:0], 3'b000} +: 8];
    hw  = r[{a[1], 4'b0000} +: 16];
    res = r;
    unique case (1'b1)
      (w == W_B):  res = {{24{by[7]}}, by};
      (w == W_BU): res = {24'd0, by};
      (w == W_H):  res = {{16{hw[15]}}, hw};
      (w == W_HU): res = {16'd0, hw};
      default: ;
    endcase
    return res;
  endfunction

  state_e         state_q, state_d;
  logic [1:0]     k_q, k_d;
  logic           we_q, we_d;
  logic [2:0]     width_q, width_d;
  logic [31:0]    addr_q, addr_d;
  logic [127:0]   wdata_q, wdata_d;
  logic           req_q, req_d;
  logic           mwe_q, mwe_d;
  logic [31:0]    maddr_q, maddr_d;
  logic [31:0]    mwdata_q, mwdata_d;
  logic [3:0]     mbe_q, mbe_d;
  logic [127:0]   ld_q, ld_d;
  logic           lv_q, lv_d;

  logic           fire;
  logic           last;
  beat_t          beat_in;
  beat_t          beat_nx;
  logic           unused_alu_hi;

  assign unused_alu_hi = ^ALU_result_bus_M[127:32];

  assign fire = (state_q == ACCESS) & req_q & mem_ready;
  assign last = (width_q != W_VEC) | (k_q == 2'd3);

  assign beat_in = mk_beat(width_type_M, ALU_result_bus_M[31:0],
                           write_data_bus_M, 2'd0);
  assign beat_nx = mk_beat(width_q, addr_q, wdata_q, k_q + 2'd1);

  always_ff @(posedge clock or negedge async_reset) begin
    if (!async_reset) begin
      state_q  <= IDLE;
      k_q      <= '0;
      we_q     <= 1'b0;
      width_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      req_q    <= 1'b0;
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      mbe_q    <= '0;
      ld_q     <= '0;
      lv_q     <= 1'b0;
    end else if (!sync_reset) begin
      state_q  <= IDLE;
      k_q      <= '0;
      we_q     <= 1'b0;
      width_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      req_q    <= 1'b0;
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      mbe_q    <= '0;
      ld_q     <= '0;
      lv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      we_q     <= we_d;
      width_q  <= width_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      req_q    <= req_d;
      mwe_q    <= mwe_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      mbe_q    <= mbe_d;
      ld_q     <= ld_d;
      lv_q     <= lv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (memory_transaction_M) state_d = ACCESS;
      ACCESS:  if (fire && last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    k_d      = k_q;
    we_d     = we_q;
    width_d  = width_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    req_d    = req_q;
    mwe_d    = mwe_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    mbe_d    = mbe_q;
    ld_d     = ld_q;
    lv_d     = 1'b0;
    if (state_q == IDLE && memory_transaction_M) begin
      k_d      = 2'd0;
      we_d     = mem_write_M;
      width_d  = width_type_M;
      addr_d   = ALU_result_bus_M[31:0];
      wdata_d  = write_data_bus_M;
      req_d    = 1'b1;
      mwe_d    = mem_write_M;
      maddr_d  = beat_in.addr;
      mwdata_d = beat_in.wdata;
      mbe_d    = beat_in.be;
    end
    if (fire) begin
      k_d = k_q + 2'd1;
      if (!we_q) begin
        if (width_q == W_VEC)
          ld_d[{k_q, 5'd0} +: 32] = mem_rdata;
        else
          ld_d = {96'd0, ld_ext(width_q, addr_q, mem_rdata)};
      end
      if (last) begin
        req_d = 1'b0;
        mwe_d = 1'b0;
        lv_d  = !we_q;
      end else begin
        maddr_d  = beat_nx.addr;
        mwdata_d = beat_nx.wdata;
        mbe_d    = beat_nx.be;
      end
    end
  end

  // Stall is combinational so the pipeline holds in the launch cycle itself.
  assign stall = ((state_q == IDLE) & memory_transaction_M)
               | (state_q == ACCESS);

  assign mem_req    = req_q;
  assign mem_we     = mwe_q;
  assign mem_addr   = maddr_q;
  assign mem_wdata  = mwdata_q;
  assign mem_be     = mbe_q;
  assign load_data  = ld_q;
  assign load_valid = lv_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: byte-addressed memory model, directed cases
// followed by randomized loads/stores with random ready stalls.
module tb_mem_stage_lsu;

  logic         clock = 1'b0;
  logic         async_reset;
  logic         sync_reset;
  logic         memory_transaction_M;
  logic         mem_write_M;
  logic [2:0]   width_type_M;
  logic [127:0] ALU_result_bus_M;
  logic [127:0] write_data_bus_M;
  logic         mem_ready;
  logic [31:0]  mem_rdata;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [3:0]   mem_be;
  logic         stall;
  logic [127:0] load_data;
  logic         load_valid;

  mem_stage_lsu dut (
    .clock                (clock),
    .async_reset          (async_reset),
    .sync_reset           (sync_reset),
    .memory_transaction_M (memory_transaction_M),
    .mem_write_M          (mem_write_M),
    .width_type_M         (width_type_M),
    .ALU_result_bus_M     (ALU_result_bus_M),
    .write_data_bus_M     (write_data_bus_M),
    .mem_ready            (mem_ready),
    .mem_rdata            (mem_rdata),
    .mem_req              (mem_req),
    .mem_we               (mem_we),
    .mem_addr             (mem_addr),
    .mem_wdata            (mem_wdata),
    .mem_be               (mem_be),
    .stall                (stall),
    .load_data            (load_data),
    .load_valid           (load_valid)
  );

  always #5 clock = ~clock;

  int           vectors = 0;
  int           errs    = 0;
  int           wr_count = 0;
  logic [7:0]   mem [bit [31:0]];
  bit           rdy_q [$];
  logic [127:0] last_load = '0;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rd_byte(input bit [31:0] a);
    bit [31:0] t;
    if (mem.exists(a)) return mem[a];
    t = a * 32'd37 + 32'd11;
    return t[7:0];
  endfunction

  function automatic logic [31:0] rd_word(input bit [31:0] a);
    return {rd_byte(a + 3), rd_byte(a + 2), rd_byte(a + 1), rd_byte(a)};
  endfunction

  task automatic wr_word(input bit [31:0] a, input logic [31:0] v);
    for (int i = 0; i < 4; i++) mem[a + i] = v[8*i +: 8];
  endtask

  function automatic logic [127:0] exp_load(input bit [2:0] w,
                                            input bit [31:0] a);
    logic [127:0] r;
    logic [7:0]   b;
    logic [15:0]  h;
    r = '0;
    if (w == 3'd7) begin
      for (int i = 0; i < 16; i++)
        r[8*i +: 8] = rd_byte((a & ~32'hF) + i);
    end else if (w == 3'd0 || w == 3'd4) begin
      b = rd_byte(a);
      r[31:0] = (w == 3'd0) ? {{24{b[7]}}, b} : {24'd0, b};
    end else if (w == 3'd1 || w == 3'd5) begin
      h = {rd_byte((a & ~32'h1) + 1), rd_byte(a & ~32'h1)};
      r[31:0] = (w == 3'd1) ? {{16{h[15]}}, h} : {16'd0, h};
    end else begin
      r[31:0] = rd_word(a & ~32'h3);
    end
    return r;
  endfunction

  // Memory side: answer the current beat and commit stores on handshake.
  task automatic serve(input bit rdy, output bit fire);
    mem_ready = rdy;
    mem_rdata = rd_word(mem_addr);
    fire = mem_req && rdy;
    if (fire && mem_we) begin
      wr_count++;
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) mem[mem_addr + i] = mem_wdata[8*i +: 8];
    end
  endtask

  task automatic op(input bit mt, input bit we, input bit [2:0] w,
                    input bit [31:0] a, input logic [127:0] d);
    bit           vec, rdy, fire, st;
    int           nb, done, cyc, stalls, waits;
    logic [127:0] el;
    bit   [31:0]  ea;
    logic [3:0]   ebe;
    logic [31:0]  ewd;
    memory_transaction_M = mt;
    mem_write_M          = we;
    width_type_M         = w;
    ALU_result_bus_M     = {$urandom(), $urandom(), $urandom(), a};
    write_data_bus_M     = d;
    if (!mt) begin
      @(negedge clock);
      chk("nomem_stall", stall, 0);
      chk("nomem_req", mem_req, 0);
      serve(1'b0, fire);
      @(posedge clock);
      #1;
      return;
    end
    vec    = (w == 3'd7);
    nb     = vec ? 4 : 1;
    el     = exp_load(w, a);
    done   = 0;
    cyc    = 0;
    stalls = 0;
    waits  = 0;
    forever begin
      @(negedge clock);
      chk("stall", stall, done < nb);
      chk("req", mem_req, (cyc > 0) && (done < nb));
      chk("lvalid", load_valid, (done == nb) && !we);
      if (done == nb) chk("ldata", load_data, we ? last_load : el);
      if (mem_req && done < nb) begin
        ea  = vec ? (a & ~32'hF) + 32'(4 * done) : (a & ~32'h3);
        ebe = 4'hF;
        ewd = d[31:0];
        if (vec) ewd = d[32*done +: 32];
        else if (w[1:0] == 2'b00) begin
          ebe = 4'b0001 << a[1:0];
          ewd = {4{d[7:0]}};
        end else if (w[1:0] == 2'b01) begin
          ebe = 4'b0011 << (a & 32'h2);
          ewd = {2{d[15:0]}};
        end
        chk("addr", mem_addr, ea);
        chk("be", mem_be, ebe);
        chk("wdata", mem_wdata, ewd);
        chk("we", mem_we, we);
      end
      if (stall) stalls++;
      if (rdy_q.size() != 0) rdy = mem_req ? rdy_q.pop_front() : 1'b0;
      else rdy = ($urandom_range(0, 2) != 0);
      if (mem_req && !rdy && done < nb) waits++;
      serve(rdy, fire);
      if (fire) done++;
      st = stall;
      @(posedge clock);
      #1;
      cyc++;
      if (!st) break;
      if (cyc > 40) begin
        vectors++;
        errs++;
        $error("FAIL timeout got=%0d cycles exp<=40", cyc);
        break;
      end
    end
    chk("stall_cycles", 128'(stalls), 128'(1 + nb + waits));
    if (!we) last_load = el;
  endtask

  initial begin
    bit           f;
    logic [31:0]  pre8, pre12;
    logic [127:0] vd;
    async_reset          = 1'b0;
    sync_reset           = 1'b1;
    memory_transaction_M = 1'b1;
    mem_write_M          = 1'b0;
    width_type_M         = 3'd2;
    ALU_result_bus_M     = 128'h10;
    write_data_bus_M     = '0;
    mem_ready            = 1'b0;
    mem_rdata            = '0;

    @(negedge clock);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_ldata", load_data, 0);
    chk("rst_lvalid", load_valid, 0);
    chk("rst_stall", stall, 1);
    @(posedge clock);
    #1;
    async_reset = 1'b1;
    op(1, 0, 3'd2, 32'h10, '0);

    wr_word(32'h100, 32'h80FF_FF7F);
    rdy_q = '{1'b1};
    op(1, 0, 3'd0, 32'h103, '0);
    chk("lb_result", load_data, 128'hFFFF_FF80);

    rdy_q = '{1'b1};
    op(1, 1, 3'd1, 32'h22, 128'h1234);
    chk("sh_mem", rd_word(32'h20) >> 16, 32'h1234);

    wr_word(32'h40, 32'hA);
    wr_word(32'h44, 32'hB);
    wr_word(32'h48, 32'hC);
    wr_word(32'h4C, 32'hD);
    rdy_q = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    op(1, 0, 3'd7, 32'h4C, '0);
    chk("vld_result", load_data,
        128'h0000000D_0000000C_0000000B_0000000A);

    // Vector store flushed by sync_reset after its second beat.
    pre8  = rd_word(32'h308);
    pre12 = rd_word(32'h30C);
    vd    = {$urandom(), $urandom(), $urandom(), $urandom()};
    wr_count             = 0;
    memory_transaction_M = 1'b1;
    mem_write_M          = 1'b1;
    width_type_M         = 3'd7;
    ALU_result_bus_M     = 128'h300;
    write_data_bus_M     = vd;
    @(negedge clock);
    serve(1'b0, f);
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("flush_b0", mem_addr, 32'h300);
    serve(1'b1, f);
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("flush_b1", mem_addr, 32'h304);
    serve(1'b1, f);
    sync_reset = 1'b0;
    @(posedge clock);
    #1;
    sync_reset           = 1'b1;
    memory_transaction_M = 1'b0;
    @(negedge clock);
    chk("flush_req", mem_req, 0);
    chk("flush_stall", stall, 0);
    chk("flush_addr", mem_addr, 0);
    chk("flush_ldata", load_data, 0);
    chk("flush_writes", 128'(wr_count), 128'd2);
    chk("flush_w2", rd_word(32'h308), pre8);
    chk("flush_w3", rd_word(32'h30C), pre12);
    serve(1'b0, f);
    @(posedge clock);
    #1;
    last_load = '0;
    op(1, 0, 3'd2, 32'h304, '0);
    chk("flush_w1", load_data, 128'(vd[63:32]));

    mem[32'h6] = 8'hEF;
    mem[32'h7] = 8'hBE;
    rdy_q = '{1'b1};
    op(1, 0, 3'd5, 32'h6, '0);
    chk("lhu_result", load_data, 128'h0000_BEEF);
    rdy_q = '{1'b1};
    op(1, 0, 3'd2, 32'h8, '0);
    op(0, 0, 3'd2, 32'h0, '0);

    for (int n = 0; n < 120; n++) begin
      op(($urandom_range(0, 4) != 0), $urandom_range(0, 1),
         3'($urandom_range(0, 7)), 32'h200 + $urandom_range(0, 63),
         {$urandom(), $urandom(), $urandom(), $urandom()});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
